// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_arbiter
// Purpose  : Round-robin two-requester I2C master issuing single-byte writes.
// Revision : 1.0
// ============================================================================
module i2c_bus_arbiter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       sda_i,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       scl_o,
    output logic       sda_o
);

    localparam int            QW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          ack_q, ack_d;
    logic          ptr_q, ptr_d;
    logic [1:0]    grant_q, grant_d;
    logic          nack_q, nack_d;
    logic          busy_q, done_q, scl_q, sda_q;
    logic          q_end, win;

    // Line levels {scl, sda} for a given position in the transaction.
    function automatic logic [1:0] lines(input state_t s, input logic [1:0] ph, input logic b);
        logic [1:0] l;
        l = 2'b11;
        case (s)
            S_START:         l = (ph == 2'd0) ? 2'b10 : 2'b00;
            S_ADDR, S_DATA:  l = {ph[1], b};
            S_AACK, S_DACK:  l = {ph[1], 1'b1};
            S_STOP:          l = (ph == 2'd0) ? 2'b00 : (ph == 2'd1) ? 2'b10 : 2'b11;
            default:         l = 2'b11;
        endcase
        return l;
    endfunction

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        ack_d   = ack_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        nack_d  = nack_q;
        win     = 1'b0;
        q_end   = (qcnt_q == Q_LAST);
        qcnt_d  = q_end ? '0 : qcnt_q + 1'b1;

        // ACK sampled on the last clk of Q2, decided at the end of Q3.
        if ((state_q == S_AACK || state_q == S_DACK) && phase_q == 2'd2 && q_end)
            ack_d = sda_i;

        case (state_q)
            S_IDLE: begin
                qcnt_d = '0;
                if (|req) begin
                    win     = (req == 2'b11) ? ~ptr_q : req[1];
                    state_d = S_START;
                    phase_d = 2'd0;
                    ptr_d   = win;
                    grant_d = win ? 2'b10 : 2'b01;
                    shift_d = win ? {addr1, 1'b0} : {addr0, 1'b0};
                    byte_d  = win ? data1 : data0;
                    nack_d  = 1'b0;
                end
            end
            S_START: begin
                if (q_end) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd1) begin
                        state_d = S_ADDR;
                        phase_d = 2'd0;
                        bit_d   = 3'd0;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (q_end) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (bit_q == 3'd7) begin
                            state_d = (state_q == S_ADDR) ? S_AACK : S_DACK;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                end
            end
            S_AACK: begin
                if (q_end) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (ack_q) begin
                            nack_d  = 1'b1;
                            state_d = S_STOP;
                        end else begin
                            state_d = S_DATA;
                            shift_d = byte_q;
                            bit_d   = 3'd0;
                        end
                    end
                end
            end
            S_DACK: begin
                if (q_end) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        nack_d  = ack_q;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (q_end) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd2) begin
                        state_d = S_DONE;
                        phase_d = 2'd0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                qcnt_d  = '0;
                phase_d = 2'd0;
                grant_d = 2'b00;
                nack_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            phase_q <= 2'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            byte_q  <= 8'd0;
            ack_q   <= 1'b0;
            ptr_q   <= 1'b1;
            grant_q <= 2'b00;
            nack_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            qcnt_q         <= qcnt_d;
            phase_q        <= phase_d;
            bit_q          <= bit_d;
            shift_q        <= shift_d;
            byte_q         <= byte_d;
            ack_q          <= ack_d;
            ptr_q          <= ptr_d;
            grant_q        <= grant_d;
            nack_q         <= nack_d;
            busy_q         <= (state_d != S_IDLE);
            done_q         <= (state_d == S_DONE);
            {scl_q, sda_q} <= lines(state_d, phase_d, shift_d[7]);
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign nack  = nack_q;
    assign scl_o = scl_q;
    assign sda_o = sda_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_arbiter
// Purpose  : Directed, table-driven self-checking bench for i2c_bus_arbiter.
// Revision : 1.0
// ============================================================================
module tb_i2c_bus_arbiter;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [6:0] addr0, addr1;
    logic [7:0] data0, data1;
    logic       sda_i;
    logic [1:0] grant;
    logic       busy, done, nack, scl_o, sda_o;

    i2c_bus_arbiter #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset(reset), .req(req),
        .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
        .sda_i(sda_i), .grant(grant), .busy(busy), .done(done), .nack(nack),
        .scl_o(scl_o), .sda_o(sda_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: START/STOP detection and SDA captured on every SCL rise.
    int          starts = 0, stops = 0, mon_cnt = 0;
    logic [31:0] mon_bits = '0;
    logic        scl_p = 1'b1, sda_p = 1'b1;
    logic        aack_lvl = 1'b0, dack_lvl = 1'b0;

    always @(negedge clk) begin
        if (scl_p && scl_o && sda_p && !sda_o) begin
            starts++;
            mon_cnt  = 0;
            mon_bits = '0;
        end
        if (scl_p && scl_o && !sda_p && sda_o) stops++;
        if (!scl_p && scl_o) begin
            mon_bits = {mon_bits[30:0], sda_o};
            mon_cnt++;
        end
        scl_p = scl_o;
        sda_p = sda_o;
    end

    // The ninth SCL rise is the address ACK slot; later ones belong to data.
    assign sda_i = (mon_cnt <= 9) ? aack_lvl : dack_lvl;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input logic [1:0] eg, input logic en, input int elat,
                           input logic [18:0] eb, input int enb,
                           input bit gapchk, input bit midchg);
        int w, t0, s0, p0;
        bit got;
        s0 = starts; p0 = stops; got = 0; w = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            w++;
            if (grant != 2'b00) got = 1;
        end
        check("grant_seen", 32'(got), 32'd1);
        if (got) begin
            t0 = cyc;
            check("grant", 32'(grant), 32'(eg));
            check("busy", 32'(busy), 32'd1);
            if (gapchk) check("idle_gap", 32'(w), 32'd1);
            got = 0;
            for (int i = 0; i < 400 && !got; i++) begin
                @(negedge clk);
                if (midchg && i == 50) begin
                    data0 = 8'h00;
                    addr0 = 7'h11;
                    req   = 2'b00;
                end
                if (done) got = 1;
            end
            check("done_seen", 32'(got), 32'd1);
            check("latency", 32'(cyc - t0), 32'(elat));
            check("nack", 32'(nack), 32'(en));
            check("grant_at_done", 32'(grant), 32'(eg));
            check("bits", 32'(mon_bits[18:0]), 32'(eb));
            check("nbits", 32'(mon_cnt), 32'(enb));
            check("start_seen", 32'(starts - s0), 32'd1);
            check("stop_seen", 32'(stops - p0), 32'd1);
            @(negedge clk);
            check("idle_after", 32'({grant, busy, nack, done}), 32'd0);
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [6:0]  a0, a1;
        logic [7:0]  d0, d1;
        logic        aack, dack;
        logic [1:0]  egrant;
        logic        enack;
        int          elat;
        logic [18:0] ebits;
        int          enb;
    } vec_t;

    vec_t        vecs[5];
    logic [18:0] bits_a, bits_b;
    bit          got;

    initial begin
        bits_a = {8'hA0, 1'b1, 8'hA5, 1'b1, 1'b0};
        bits_b = {8'h54, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[0] = '{2'b01, 7'h50, 7'h00, 8'hA5, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 308, bits_a, 19};
        vecs[1] = '{2'b01, 7'h50, 7'h00, 8'hA5, 8'h00, 1'b1, 1'b0, 2'b01, 1'b1, 164,
                    19'({8'hA0, 1'b1, 1'b0}), 10};
        vecs[2] = '{2'b10, 7'h00, 7'h2A, 8'h00, 8'h3C, 1'b0, 1'b1, 2'b10, 1'b1, 308, bits_b, 19};
        vecs[3] = '{2'b10, 7'h00, 7'h7F, 8'h00, 8'hFF, 1'b0, 1'b0, 2'b10, 1'b0, 308,
                    {8'hFE, 1'b1, 8'hFF, 1'b1, 1'b0}, 19};
        vecs[4] = '{2'b01, 7'h00, 7'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 308,
                    {8'h00, 1'b1, 8'h00, 1'b1, 1'b0}, 19};

        reset = 1'b0; req = 2'b11;
        addr0 = 7'h50; addr1 = 7'h2A; data0 = 8'hA5; data1 = 8'h3C;
        repeat (4) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_lines", 32'({scl_o, sda_o}), 32'd3);
        check("rst_done", 32'({done, busy, nack}), 32'd0);
        req = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            addr0 = vecs[v].a0; addr1 = vecs[v].a1;
            data0 = vecs[v].d0; data1 = vecs[v].d1;
            aack_lvl = vecs[v].aack; dack_lvl = vecs[v].dack;
            req = vecs[v].req;
            run_txn(vecs[v].egrant, vecs[v].enack, vecs[v].elat, vecs[v].ebits, vecs[v].enb, 1'b0, 1'b0);
            req = 2'b00;
            repeat (2) @(negedge clk);
        end

        // Round-robin from a fresh reset with both requesters held.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        addr0 = 7'h50; data0 = 8'hA5; addr1 = 7'h2A; data1 = 8'h3C;
        aack_lvl = 1'b0; dack_lvl = 1'b0;
        @(negedge clk);
        req = 2'b11;
        run_txn(2'b01, 1'b0, 308, bits_a, 19, 1'b0, 1'b0);
        run_txn(2'b10, 1'b0, 308, bits_b, 19, 1'b1, 1'b0);
        run_txn(2'b01, 1'b0, 308, bits_a, 19, 1'b1, 1'b0);
        req = 2'b00;
        repeat (2) @(negedge clk);

        // Reset during DATA bit 3 (Q1: both lines low), then restart.
        req = 2'b01;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (grant != 2'b00) got = 1;
        end
        check("mid_grant_seen", 32'(got), 32'd1);
        req = 2'b00;
        repeat (205) @(negedge clk);
        check("mid_pre_lines", 32'({scl_o, sda_o}), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_lines", 32'({scl_o, sda_o}), 32'd3);
        check("mid_rst_grant", 32'({grant, busy}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        req = 2'b11;
        run_txn(2'b01, 1'b0, 308, bits_a, 19, 1'b0, 1'b0);
        req = 2'b00;
        repeat (2) @(negedge clk);

        // Inputs changed and req dropped during ADDR: latched values still sent.
        addr0 = 7'h50; data0 = 8'hA5;
        req = 2'b01;
        run_txn(2'b01, 1'b0, 308, bits_a, 19, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("no_regrant", 32'({grant, busy}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Two-requester I2C master that shares one SCL/SDA bus and sequences complete single-byte write transactions on it. It arbitrates round-robin between requesters, then generates START, address+W, ACK check, data byte, ACK check and STOP. It drives the same scl/sda lines that the unidFSM bus monitor decodes, so that monitor can observe every transaction it issues.

## Interface
- CLK_DIV, 4, clk cycles per SCL quarter-period; legal range ≥1.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  2  request per requester; level-sensitive, sampled only in IDLE.
- addr0, addr1  input  7  7-bit slave address per requester; latched at grant.
- data0, data1  input  8  write byte per requester; latched at grant.
- sda_i  input  1  sampled SDA line, used for ACK detection.
- grant  output  2  one-hot owner of the current transaction; 0 when idle.
- busy  output  1  high from the grant cycle through the DONE cycle.
- done  output  1  one-cycle completion pulse.
- nack  output  1  valid with done; 1 means the address or data was not acknowledged.
- scl_o  output  1  SCL drive; 1 means released/high.
- sda_o  output  1  SDA drive; 1 means released/high.

## Operation
- Reset values: grant=0, busy=0, done=0, nack=0, scl_o=1, sda_o=1, state=IDLE, round-robin pointer=1 (requester 0 wins first tie).
- Asserting reset mid-transaction aborts at once and releases both lines. No STOP is generated.
- States: IDLE, START, ADDR, AACK, DATA, DACK, STOP, DONE.
- Timing unit is a quarter (Q) = CLK_DIV cycles. A quarter counter plus a 2-bit phase index step through each state.
- IDLE: scl_o=1, sda_o=1. If any req bit is set, grant the requester next after the pointer (round-robin). Latch shift register = {addrN, 1'b0} and the data byte, update the pointer, and go to START.
- START (2Q): Q0 scl=1 sda=0; Q1 scl=0 sda=0.
- Bit cell (ADDR, DATA, and both ACK slots), 4Q, MSB first:
  - Q0 and Q1: scl=0, sda=bit.
  - Q2 and Q3: scl=1, sda held.
  - ACK slots drive sda=1 and sample sda_i on the last clk of Q2. 0 = ACK.
- ADDR: 8 bits, then AACK. A NACK sets nack and skips to STOP; otherwise go to DATA.
- DATA: 8 bits, then DACK. A NACK sets nack. Go to STOP.
- STOP (3Q): Q0 scl=0 sda=0; Q1 scl=1 sda=0; Q2 scl=1 sda=1.
- DONE (1 cycle): done=1, nack valid, grant still asserted. Next cycle: IDLE, grant=0, busy=0, nack cleared.
- Requester inputs change or req deasserts during a transaction: ignored.
- Both requesting in IDLE: the requester not granted last wins. A single requester held high is re-granted back-to-back.

## Timing
- grant, busy, and the START Q0 line levels all appear in the cycle after IDLE samples req. Call that cycle T0.
- Full ACKed transaction: 77Q. done at T0 + 77·CLK_DIV; with CLK_DIV=4, done at T0+308.
- Address NACK: 41Q. done at T0 + 41·CLK_DIV; with CLK_DIV=4, done at T0+164.
- Minimum gap between a done pulse and the next grant: 2 cycles (the IDLE cycle that samples req, then the grant cycle).
- Line transitions occur only on quarter boundaries. SDA changes only while scl_o=0, except at START and STOP.

## Test plan
- **Reset:** hold reset=0 with req=2'b11. Required: grant=0, scl_o=sda_o=1, done=0.
- **Single write, ACK:** req=01, addr0=7'h50, data0=8'hA5, sda_i=0 in both ACK slots, CLK_DIV=4. Required:
  - SDA bit sequence 1010_0000 then 1010_0101.
  - done at T0+308 with nack=0.
  - A bus monitor sees START then STOP.
- **Address NACK:** same as above but sda_i=1 in AACK. Required: no data bits driven; STOP follows; done at T0+164 with nack=1.
- **Round-robin:** req=11 held over three transactions. Required: grants 01, 10, 01. Each done pulse is followed by grant=0 for exactly 1 cycle.
- **Reset mid-operation:** reset=0 during DATA bit 3. Required: scl_o=sda_o=1 immediately and grant=0. After release, a new req starts from START and the pointer is back at its reset value.
- **Input change mid-transaction:** change data0 and drop req during ADDR. Required: the originally latched byte is sent and done still fires.
